// File: rtl/addr_map_pkg.sv
// Shared address map: HADDR[31:28] region nibbles owned by the data-port slaves.
package addr_map_pkg;
   localparam logic [3:0] DATA_S00_HIT = 4'h1;
   localparam logic [3:0] DATA_S01_HIT = 4'h2;
   localparam logic [3:0] DATA_S02_HIT = 4'h3;
   localparam logic [3:0] DATA_S03_HIT = 4'h4;
   localparam logic [3:0] DATA_S04_HIT = 4'h5;
   localparam logic [3:0] DATA_S05_HIT = 4'h6;
   localparam logic [3:0] DATA_S06_HIT = 4'h7;
   localparam logic [3:0] DATA_S07_HIT = 4'h8;
   localparam logic [3:0] DATA_S08_HIT = 4'h9;
   localparam logic [3:0] DATA_S09_HIT = 4'hA;
   localparam logic [3:0] DATA_S10_HIT = 4'hB;
   localparam logic [3:0] DATA_S11_HIT = 4'hC;
   localparam logic [3:0] DATA_S12_HIT = 4'hD;
   localparam logic [3:0] DATA_S13_HIT = 4'hE;
   localparam logic [3:0] DATA_S14_HIT = 4'hF;
endpackage

// File: rtl/ahb_pkg.sv
// AHB-Lite encodings plus the data-phase select and default-slave state types.
package ahb_pkg;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // Values 0..14 double as the slave index, so [3:0] selects the slave directly.
   typedef enum logic [4:0] {
      DP_S00 = 5'd0,  DP_S01 = 5'd1,  DP_S02 = 5'd2,  DP_S03 = 5'd3,
      DP_S04 = 5'd4,  DP_S05 = 5'd5,  DP_S06 = 5'd6,  DP_S07 = 5'd7,
      DP_S08 = 5'd8,  DP_S09 = 5'd9,  DP_S10 = 5'd10, DP_S11 = 5'd11,
      DP_S12 = 5'd12, DP_S13 = 5'd13, DP_S14 = 5'd14,
      DP_DEFAULT = 5'd15,
      DP_NONE    = 5'd16
   } dp_sel_e;

   typedef enum logic [1:0] {
      DS_IDLE = 2'd0,
      DS_ERR1 = 2'd1,
      DS_ERR2 = 2'd2
   } ds_state_e;

   function automatic logic htrans_active(input logic [1:0] trans);
      return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
   endfunction
endpackage

// File: rtl/system_pkg.sv
// System-wide bus widths shared by all interconnect stages.
package system_pkg;
   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;
endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped data addresses: two-cycle ERROR for NONSEQ/SEQ, zero-wait OKAY otherwise.
// Accepts a new transfer only when the global HREADY is high; ERR1 advances regardless.
module ahb_default_slave
   import ahb_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       hready_i,
   input  logic       hsel_i,
   input  logic [1:0] htrans_i,
   output logic       hreadyout_o,
   output logic       hresp_o
);

   ds_state_e state_q, state_d;
   logic      start;

   assign start = hready_i & hsel_i & htrans_active(htrans_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= DS_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         DS_IDLE: if (start) state_d = DS_ERR1;
         DS_ERR1: state_d = DS_ERR2;
         DS_ERR2: state_d = start ? DS_ERR1 : DS_IDLE;
         default: state_d = DS_IDLE;
      endcase
   end

   // Outputs decode state only, keeping them off the HREADY feedback path.
   always_comb begin
      hreadyout_o = 1'b1;
      hresp_o     = HRESP_OKAY;
      unique case (state_q)
         DS_ERR1: begin
            hreadyout_o = 1'b0;
            hresp_o     = HRESP_ERROR;
         end
         DS_ERR2: hresp_o = HRESP_ERROR;
         default: ;
      endcase
   end

endmodule

// File: rtl/ahb_data_decoder.sv
// Data-port AHB-Lite decoder: combinational HSEL from HADDR[31:28]; data-phase response muxed from the
// slave latched one cycle behind, held while HREADY is low.
module ahb_data_decoder
   import ahb_pkg::*;
   import addr_map_pkg::*;
#(
   parameter int ADDR_WIDTH = system_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = system_pkg::DATA_WIDTH,
   parameter int NUM_SLAVES = 15
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [ADDR_WIDTH-1:0]            haddr_i,
   input  logic [1:0]                       htrans_i,
   output logic                             hready_o,
   output logic [DATA_WIDTH-1:0]            hrdata_o,
   output logic                             hresp_o,
   output logic [NUM_SLAVES-1:0]            hsel_o,
   input  logic [NUM_SLAVES-1:0]            s_hreadyout_i,
   input  logic [NUM_SLAVES-1:0]            s_hresp_i,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_hrdata_i
);

   if (NUM_SLAVES != 15) begin : g_bad_num_slaves
      $error("ahb_data_decoder: NUM_SLAVES must be 15 to match the address map");
   end

   localparam logic [3:0] DATA_HIT [15] = '{
      DATA_S00_HIT, DATA_S01_HIT, DATA_S02_HIT, DATA_S03_HIT, DATA_S04_HIT,
      DATA_S05_HIT, DATA_S06_HIT, DATA_S07_HIT, DATA_S08_HIT, DATA_S09_HIT,
      DATA_S10_HIT, DATA_S11_HIT, DATA_S12_HIT, DATA_S13_HIT, DATA_S14_HIT
   };

   logic [3:0]            nibble;
   logic [NUM_SLAVES-1:0] hsel;
   logic                  dflt_sel;
   dp_sel_e               dec_sel;
   dp_sel_e               dp_sel_q, dp_sel_d;
   logic [3:0]            dp_idx;
   logic                  ds_hreadyout;
   logic                  ds_hresp;
   logic                  unused_haddr;

   assign nibble       = haddr_i[ADDR_WIDTH-1 -: 4];
   assign unused_haddr = ^haddr_i[ADDR_WIDTH-5:0];

   always_comb begin
      hsel     = '0;
      dflt_sel = 1'b1;
      dec_sel  = DP_DEFAULT;
      for (int k = 0; k < NUM_SLAVES; k++) begin
         if (nibble == DATA_HIT[k]) begin
            hsel[k]  = 1'b1;
            dflt_sel = 1'b0;
            dec_sel  = dp_sel_e'(k[4:0]);
         end
      end
   end

   assign hsel_o = hsel;

   // Address phase is only accepted while HREADY is high.
   assign dp_sel_d = hready_o ? dec_sel : dp_sel_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) dp_sel_q <= DP_NONE;
      else       dp_sel_q <= dp_sel_d;
   end

   ahb_default_slave u_default_slave (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .hready_i    (hready_o),
      .hsel_i      (dflt_sel),
      .htrans_i    (htrans_i),
      .hreadyout_o (ds_hreadyout),
      .hresp_o     (ds_hresp)
   );

   assign dp_idx = dp_sel_q[3:0];

   always_comb begin
      hready_o = 1'b1;
      hresp_o  = HRESP_OKAY;
      hrdata_o = '0;
      if (dp_sel_q == DP_NONE) begin
         hready_o = 1'b1;
      end else if (dp_sel_q == DP_DEFAULT) begin
         hready_o = ds_hreadyout;
         hresp_o  = ds_hresp;
      end else begin
         hready_o = s_hreadyout_i[dp_idx];
         hresp_o  = s_hresp_i[dp_idx];
         hrdata_o = s_hrdata_i[int'(dp_idx)*DATA_WIDTH +: DATA_WIDTH];
      end
   end

endmodule
